// File: rtl/perfil_pasos_pkg.sv
// Shared definitions for the stepper motion-profile generator.
// Holds the FSM state encoding and the default timing constants
// (in clk cycles at 50 MHz) used by perfil_pasos_motor.
package perfil_pasos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEL  = 3'd1,
        ST_CRUISE = 3'd2,
        ST_DECEL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int CLK_HZ_DEF  = 50_000_000;
    localparam int P_START_DEF = 250_000;   // 200 Hz first/last step
    localparam int P_MIN_DEF   = 100_000;   // 500 Hz cruise, motor limit
    localparam int P_DELTA_DEF = 10_000;    // interval change per ramp step

endpackage

// File: rtl/temporizador_paso.sv
// Step interval timer: loadable down-counter with a one-cycle expiry strobe.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   clr        - synchronous clear of the count (wins over load)
//   load       - load load_val into the count (wins over counting)
//   load_val   - interval in clk cycles
//   en         - counting enable
//   expire     - high in the cycle where the count is 1, i.e. the next
//                edge is the step edge
module temporizador_paso
    import perfil_pasos_pkg::*;
#(
    parameter int PER_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [PER_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Loading N at an edge makes expire high N-1 cycles later, so the
    // owner's registered strobe lands exactly N edges after the load.
    assign expire = en && !clr && (count_reg == PER_W'(1));

endmodule

// File: rtl/perfil_pasos_motor.sv
// Trapezoidal/triangular motion-profile step generator for the 28BYJ-48.
// Emits one-clk step strobes whose spacing ramps from P_START down to P_MIN,
// cruises, and ramps back up, moving exactly the latched step count.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   start         - move request, taken only in IDLE
//   direcc        - direction, latched with start
//   target_steps  - steps to move, latched with start
//   abort         - immediate stop, no done strobe
//   step_pulse    - one-clk strobe per step
//   direcc_out    - latched direction for the whole move
//   busy          - move in progress
//   done          - one-clk strobe after a completed move
//   steps_done    - steps issued in the current or last move
module perfil_pasos_motor
    import perfil_pasos_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int STEP_W  = 12,
    parameter int PER_W   = 18,
    parameter int P_START = P_START_DEF,
    parameter int P_MIN   = P_MIN_DEF,
    parameter int P_DELTA = P_DELTA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              direcc,
    input  logic [STEP_W-1:0] target_steps,
    input  logic              abort,
    output logic              step_pulse,
    output logic              direcc_out,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    localparam logic [PER_W-1:0] PS = PER_W'(P_START);
    localparam logic [PER_W-1:0] PM = PER_W'(P_MIN);
    localparam logic [PER_W:0]   PD_W = (PER_W+1)'(P_DELTA);

    state_t            state_reg;
    logic [STEP_W-1:0] target_reg;
    logic [STEP_W-1:0] ramp_reg;
    logic [PER_W-1:0]  period_reg;

    logic              running;
    logic              expire;
    logic              accept;
    logic [STEP_W-1:0] steps_inc;
    logic [STEP_W-1:0] rem;
    logic              decel_sel;
    logic [PER_W:0]    up_wide;
    logic [PER_W-1:0]  period_up;
    logic [PER_W-1:0]  period_down;
    logic [PER_W-1:0]  period_next;
    logic [STEP_W-1:0] ramp_next;
    logic              timer_load;
    logic [PER_W-1:0]  timer_val;

    assign running   = (state_reg == ST_ACCEL) || (state_reg == ST_CRUISE) ||
                       (state_reg == ST_DECEL);
    assign accept    = (state_reg == ST_IDLE) && start;
    assign steps_inc = steps_done + 1'b1;
    assign rem       = target_reg - steps_inc;

    // Remaining steps no more than the steps spent accelerating means the
    // ramp-down has to begin now to arrive at P_START on the last step.
    assign decel_sel = (rem <= ramp_reg) || (state_reg == ST_DECEL);

    // Widened sums so the clamps never see a wrapped value.
    assign up_wide     = {1'b0, period_reg} + PD_W;
    assign period_up   = (up_wide > {1'b0, PS}) ? PS : up_wide[PER_W-1:0];
    assign period_down = ({1'b0, period_reg} < ({1'b0, PM} + PD_W)) ?
                         PM : (period_reg - PER_W'(P_DELTA));

    always_comb begin
        period_next = period_reg;
        ramp_next   = ramp_reg;
        if (decel_sel) begin
            period_next = period_up;
            ramp_next   = (ramp_reg == '0) ? '0 : ramp_reg - 1'b1;
        end else if (state_reg == ST_ACCEL) begin
            period_next = period_down;
            ramp_next   = ramp_reg + 1'b1;
        end
    end

    // The timer is reloaded on the accept edge and on every step edge that
    // does not finish the move; abort clears it so no stale strobe remains.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = PS;
        if (accept && target_steps != '0) begin
            timer_load = 1'b1;
        end else if (running && !abort && expire && rem != '0) begin
            timer_load = 1'b1;
            timer_val  = period_next;
        end
    end

    temporizador_paso #(
        .PER_W (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (running && abort),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (running),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            ramp_reg   <= '0;
            period_reg <= PS;
            step_pulse <= 1'b0;
            direcc_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_done <= '0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        direcc_out <= direcc;
                        target_reg <= target_steps;
                        steps_done <= '0;
                        ramp_reg   <= '0;
                        period_reg <= PS;
                        if (target_steps == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_ACCEL;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // start is ignored here; the strobe follows the DONE cycle.
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= !abort;
                end
                default: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                    end else if (expire) begin
                        step_pulse <= 1'b1;
                        steps_done <= steps_inc;
                        if (rem == '0) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                        end else begin
                            period_reg <= period_next;
                            ramp_reg   <= ramp_next;
                            if (decel_sel) begin
                                state_reg <= ST_DECEL;
                            end else if (state_reg == ST_ACCEL &&
                                         period_down == PM) begin
                                state_reg <= ST_CRUISE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Parameter sanity, simulation only.
    always @(posedge clk) begin
        if (!rst) begin
            assert (CLK_HZ > 0 && P_MIN >= 2 && P_START >= P_MIN)
            else $error("perfil_pasos_motor: invalid timing parameters");
        end
    end

endmodule

// File: tb/tb_perfil_pasos_motor.sv
module tb_perfil_pasos_motor;

    localparam int STEP_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              direcc = 1'b0;
    logic [STEP_W-1:0] target_steps = '0;
    logic              abort = 1'b0;
    logic              step_pulse;
    logic              direcc_out;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_done;

    int tests = 0;
    int fails = 0;

    perfil_pasos_motor #(
        .CLK_HZ  (50_000_000),
        .STEP_W  (STEP_W),
        .PER_W   (18),
        .P_START (20),
        .P_MIN   (8),
        .P_DELTA (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .direcc       (direcc),
        .target_steps (target_steps),
        .abort        (abort),
        .step_pulse   (step_pulse),
        .direcc_out   (direcc_out),
        .busy         (busy),
        .done         (done),
        .steps_done   (steps_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [STEP_W-1:0] target;
        logic              dir;
        logic              noise;
        int                n;
        int                ivl [10];
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Applies one move and checks pulse timing, busy, direction and done.
    task automatic run_move(input vec_t v);
        int cum [10];
        int acc;
        int seen;
        int done_k;
        int bad_dir;
        int bad_busy;
        int last;
        acc = 0;
        for (int i = 0; i < v.n; i++) begin
            acc += v.ivl[i];
            cum[i] = acc;
        end
        last = (v.n > 0) ? cum[v.n-1] : 0;
        direcc = v.dir;
        target_steps = v.target;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", int'(busy), (v.n > 0) ? 1 : 0);
        seen = 0; done_k = -1; bad_dir = 0; bad_busy = 0;
        for (int k = 1; k <= 400 && done_k < 0; k++) begin
            if (v.noise) begin
                start  = 1'($urandom_range(0, 1));
                direcc = ~direcc;
            end
            @(posedge clk); #1;
            if (step_pulse) begin
                if (seen < v.n) chk($sformatf("pulse%0d_cycle", seen + 1), k, cum[seen]);
                else            chk("extra_pulse", seen + 1, v.n);
                seen++;
            end
            if (direcc_out !== v.dir) bad_dir++;
            if (busy !== ((v.n > 0) && (k < last))) bad_busy++;
            if (done) done_k = k;
        end
        start = 1'b0;
        direcc = v.dir;
        chk("done_cycle", done_k, (v.n > 0) ? last + 1 : 1);
        chk("pulse_count", seen, v.n);
        chk("steps_done", int'(steps_done), int'(v.target));
        chk("direcc_out_errors", bad_dir, 0);
        chk("busy_errors", bad_busy, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        vecs[0] = '{12'd10, 1'b1, 1'b0, 10, '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20}};
        vecs[1] = '{12'd4,  1'b0, 1'b0, 4,  '{20, 16, 12, 16, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{12'd0,  1'b1, 1'b0, 0,  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{12'd1,  1'b0, 1'b0, 1,  '{20, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{12'd2,  1'b1, 1'b0, 2,  '{20, 16, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{12'd6,  1'b0, 1'b0, 6,  '{20, 16, 12, 8, 12, 16, 0, 0, 0, 0}};
        vecs[6] = '{12'd10, 1'b0, 1'b1, 10, '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step_pulse", int'(step_pulse), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_steps_done", int'(steps_done), 0);
        chk("rst_direcc_out", int'(direcc_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d: target=%0d dir=%0d noise=%0d",
                     i, vecs[i].target, vecs[i].dir, vecs[i].noise);
            run_move(vecs[i]);
        end

        // Abort coinciding with the 3rd expiry (cycle 48 of a 10-step move)
        begin
            int pulses;
            int dones;
            direcc = 1'b1; target_steps = 12'd10; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            pulses = 0;
            for (int k = 1; k <= 47; k++) begin
                @(posedge clk); #1;
                if (step_pulse) pulses++;
            end
            chk("abort_pre_pulses", pulses, 2);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_pulse_suppressed", int'(step_pulse), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_steps_done", int'(steps_done), 2);
            pulses = 0; dones = int'(done);
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (step_pulse) pulses++;
                if (done) dones++;
            end
            chk("abort_later_pulses", pulses, 0);
            chk("abort_no_done", dones, 0);
            chk("abort_steps_hold", int'(steps_done), 2);
        end

        // Asynchronous reset at the 5th pulse of a 10-step move
        begin
            int pulses;
            direcc = 1'b1; target_steps = 12'd10; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            pulses = 0;
            for (int k = 1; k <= 200 && pulses < 5; k++) begin
                @(posedge clk); #1;
                if (step_pulse) pulses++;
            end
            chk("rstmid_pulses", pulses, 5);
            #1 rst = 1'b1;
            #1;
            chk("rstmid_step_pulse", int'(step_pulse), 0);
            chk("rstmid_busy", int'(busy), 0);
            chk("rstmid_steps_done", int'(steps_done), 0);
            chk("rstmid_direcc_out", int'(direcc_out), 0);
            chk("rstmid_done", int'(done), 0);
            @(posedge clk); #2;
            rst = 1'b0;
            @(posedge clk); #1;
            run_move(vecs[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perfil_pasos_motor.md
Name: perfil_pasos_motor

Overview:
- Motion-profile step generator for the 28BYJ-48 unipolar stepper path.
- Sits upstream of the step-sequencing stage. It replaces the fixed-rate divided clock with step strobes that follow a trapezoidal (or triangular) accelerate/cruise/decelerate profile.
- Moves exactly the commanded number of steps in the latched direction, then reports completion.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency (Nexys 2); used for documentation and sanity checks only.
- STEP_W, 12, width of step count (max 4095 steps; 2048 = one output revolution in full-step).
- PER_W, 18, width of the period counter and period registers.
- P_START, 250_000, interval in clk cycles for the first and last step (200 Hz).
- P_MIN, 100_000, cruise interval in clk cycles (500 Hz, the motor limit).
- P_DELTA, 10_000, interval change per step during accel/decel.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  move request, level-sampled; accepted only in IDLE
- direcc  in  1  requested direction, latched when start is accepted
- target_steps  in  STEP_W  number of steps to move, latched when start is accepted
- abort  in  1  immediate stop
- step_pulse  out  1  one-clk strobe per step, to the step-sequencing stage
- direcc_out  out  1  latched direction, stable for the whole move
- busy  out  1  high while a move is in progress
- done  out  1  one-clk strobe when the move completes
- steps_done  out  STEP_W  steps issued in the current or last move

Behaviour:
- Reset (async, rst=1): state=IDLE, step_pulse=0, direcc_out=0, busy=0, done=0, steps_done=0, period=P_START, ramp_steps=0, timer=0.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- IDLE with start=1 at a clk edge:
  - latch direcc and target_steps; clear steps_done and ramp_steps; period=P_START.
  - If target=0, go to DONE. Otherwise go to ACCEL with busy=1 from the next cycle, and load the timer with P_START.
- start while busy, or while in the DONE state, is ignored. direcc changes mid-move are ignored.
- Timer:
  - Counts down once per clk.
  - On expiry it asserts step_pulse for exactly 1 cycle, increments steps_done, and reloads with the updated period.
  - Step k is emitted at the clk edge where the cumulative sum of intervals 1..k, counted from the start-accept edge, is reached.
- Per-step update, evaluated at each pulse with rem = target − steps_done (after increment):
  - rem=0: go to DONE.
  - Else if rem ≤ ramp_steps (value before update): go to DECEL; period=min(period+P_DELTA, P_START); ramp_steps = ramp_steps−1, saturating at 0.
  - Else in ACCEL: period=max(period−P_DELTA, P_MIN); ramp_steps+1; if the new period equals P_MIN, go to CRUISE.
  - Else in CRUISE: period unchanged.
  - Else in DECEL: keep decelerating as above.
- DONE: lasts 1 cycle with done=1 and busy=0, then goes to IDLE. steps_done holds its final value until the next accepted start.
- abort=1 in any non-IDLE state:
  - next state is IDLE; busy=0; no further pulses; done is not asserted; steps_done holds.
  - abort overrides a step expiry in the same cycle, so that pulse is suppressed.
- Arithmetic: all period math is unsigned PER_W; clamping prevents wrap. The rem comparison is STEP_W unsigned.
- Requires P_MIN ≥ 2 and P_START ≥ P_MIN; this is checked in simulation only.

Decomposition:
- Package perfil_pasos_pkg holds:
  - state encoding (IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, DONE=4, 3-bit);
  - default P_START/P_MIN/P_DELTA constants.
- One natural sub-module: temporizador_paso, a loadable down-counter with a one-cycle expiry strobe and a synchronous clear.

Test Plan (bench params P_START=20, P_MIN=8, P_DELTA=4, STEP_W=12):
- Reset mid-move at step 5 of 10 -> all outputs reset values immediately (async); new start after release behaves as a fresh move.
- start, direcc=1, target=10 -> pulse intervals 20,16,12,8,8,8,8,12,16,20; last pulse at cycle 128; done 1 cycle later; steps_done=10; direcc_out=1 throughout.
- target=4 -> intervals 20,16,12,16 (triangular); done after step 4; steps_done=4.
- target=0 -> no step_pulse; done strobe on the cycle after start; busy never asserted.
- abort in the same cycle as the 3rd pulse expiry, target=10 -> pulse suppressed; steps_done=2; busy=0 next cycle; no done.
- start toggled and direcc flipped during a move -> ignored; move completes with the original count and direction.
